// File: rtl/router_inject_port_if.sv
// Core-to-router injection bundle. The block sits on the slave side: it
// receives flits from the core and presents them, with a VC tag, to one
// router input port that returns per-VC ready, ack and lock information.
interface router_inject_port_if;
    logic        CORE_VALID;
    logic [31:0] CORE_DATA;
    logic        CORE_HEAD;
    logic        CORE_TAIL;
    logic        CORE_READY;
    logic [34:0] ODATA;
    logic        OVALID;
    logic        OVCH;
    logic [1:0]  IRDY;
    logic [1:0]  IACK;
    logic [1:0]  ILCK;

    modport slave (
        input  CORE_VALID, CORE_DATA, CORE_HEAD, CORE_TAIL,
        input  IRDY, IACK, ILCK,
        output CORE_READY, ODATA, OVALID, OVCH
    );

    modport master (
        output CORE_VALID, CORE_DATA, CORE_HEAD, CORE_TAIL,
        output IRDY, IACK, ILCK,
        input  CORE_READY, ODATA, OVALID, OVCH
    );
endinterface

// File: rtl/router_inject_port.sv
// Router injection port: buffers core flits in a small FIFO, picks a virtual
// channel for each packet at its head flit, and streams the packet to the
// router while tracking unacknowledged flits per VC as a credit limit.
module router_inject_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic                 clk,
    input  logic                 RST_,
    router_inject_port_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_r;
    logic              cur_vc_r;
    logic              err_r;
    logic [33:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [1:0][2:0]   out_cnt_r;

    logic              empty_s;
    logic              full_s;
    logic [33:0]       head_flit_s;
    logic [1:0]        credit_ok_s;
    logic              sel_s;
    logic              sel_vc_s;
    logic              drop_s;
    logic              xfer_s;
    logic              last_s;
    logic              push_s;
    logic              pop_s;
    logic              ovalid_s;
    logic [1:0]        cnt_inc_s;
    logic [1:0]        cnt_dec_s;

    // Decode FIFO status, VC selection in IDLE, router transfer in SEND
    always_comb begin
        empty_s        = (count_r == {CNT_W{1'b0}});
        full_s         = (count_r == FULL_CNT);
        head_flit_s    = mem_r[rd_ptr_r];
        credit_ok_s[0] = (out_cnt_r[0] < MAX_CNT);
        credit_ok_s[1] = (out_cnt_r[1] < MAX_CNT);
        sel_s          = 1'b0;
        sel_vc_s       = 1'b0;
        drop_s         = 1'b0;
        xfer_s         = 1'b0;
        ovalid_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    if (head_flit_s[33]) begin
                        if (!bus.ILCK[0] && credit_ok_s[0]) begin
                            sel_s    = 1'b1;
                            sel_vc_s = 1'b0;
                        end else if (!bus.ILCK[1] && credit_ok_s[1]) begin
                            sel_s    = 1'b1;
                            sel_vc_s = 1'b1;
                        end else begin
                            sel_s    = 1'b0;
                        end
                    end else begin
                        // A body flit with no open packet cannot be routed
                        drop_s = 1'b1;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end
            SEND: begin
                ovalid_s = !empty_s;
                xfer_s   = !empty_s && bus.IRDY[cur_vc_r] && credit_ok_s[cur_vc_r];
            end
            default: begin
                ovalid_s = 1'b0;
            end
        endcase
        last_s       = xfer_s && head_flit_s[32];
        push_s       = bus.CORE_VALID && !full_s;
        pop_s        = xfer_s || drop_s;
        cnt_inc_s[0] = xfer_s && !cur_vc_r;
        cnt_inc_s[1] = xfer_s && cur_vc_r;
        cnt_dec_s[0] = bus.IACK[0] && (out_cnt_r[0] != 3'd0);
        cnt_dec_s[1] = bus.IACK[1] && (out_cnt_r[1] != 3'd0);
    end

    assign bus.CORE_READY = !full_s;
    assign bus.OVALID     = ovalid_s;
    assign bus.OVCH       = cur_vc_r;
    assign bus.ODATA      = ovalid_s ? {head_flit_s[33:32], 1'b0, head_flit_s[31:0]} : 35'd0;

    // Flit FIFO storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!RST_) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {bus.CORE_HEAD, bus.CORE_TAIL, bus.CORE_DATA};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-VC outstanding flit counters; an ack with nothing outstanding is ignored
    always_ff @(posedge clk) begin
        if (!RST_) begin
            out_cnt_r <= 6'd0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                case ({cnt_inc_s[v], cnt_dec_s[v]})
                    2'b10:   out_cnt_r[v] <= out_cnt_r[v] + 3'd1;
                    2'b01:   out_cnt_r[v] <= out_cnt_r[v] - 3'd1;
                    default: out_cnt_r[v] <= out_cnt_r[v];
                endcase
            end
        end
    end

    // Packet FSM: choose the VC at a head flit, stream until the tail leaves
    always_ff @(posedge clk) begin
        if (!RST_) begin
            state_r  <= IDLE;
            cur_vc_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_s) begin
                        state_r  <= SEND;
                        cur_vc_r <= sel_vc_s;
                    end else begin
                        state_r  <= IDLE;
                    end
                    if (drop_s) begin
                        err_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_inject_port.sv
// Directed and randomized checks for router_inject_port against a
// transaction-level model: an ordered list of expected flits plus a count
// of unacknowledged flits per VC.
module tb_router_inject_port;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUT    = 4;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;

    router_inject_port_if bus();

    router_inject_port #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .RST_(rst_),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [33:0] offer_q[$];
    logic [33:0] exp_q[$];
    logic [35:0] rx_q[$];
    int          outst[2];
    logic        core_en = 1'b1;
    logic        stray   = 1'b0;
    logic [34:0] held;
    logic        pkt_vc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic h, input logic t, input logic [31:0] d);
        bus.CORE_VALID = 1'b1;
        bus.CORE_HEAD  = h;
        bus.CORE_TAIL  = t;
        bus.CORE_DATA  = d;
        cyc();
        bus.CORE_VALID = 1'b0;
        bus.CORE_HEAD  = 1'b0;
        bus.CORE_TAIL  = 1'b0;
        bus.CORE_DATA  = 32'd0;
    endtask

    // One clock: offer the next queued flit, log a router transfer, update credits
    task automatic run_cycle();
        logic acc;
        logic xf;
        logic vc;
        if (core_en && offer_q.size() > 0) begin
            bus.CORE_VALID = 1'b1;
            {bus.CORE_HEAD, bus.CORE_TAIL, bus.CORE_DATA} = offer_q[0];
        end else begin
            bus.CORE_VALID = 1'b0;
            {bus.CORE_HEAD, bus.CORE_TAIL, bus.CORE_DATA} = 34'd0;
        end
        #1;
        check("odata_bit32", 64'(bus.ODATA[32]), 64'd0);
        if (!bus.OVALID) check("odata_zero_when_invalid", 64'(bus.ODATA), 64'd0);
        acc = bus.CORE_VALID && bus.CORE_READY;
        vc  = bus.OVCH;
        xf  = bus.OVALID && bus.IRDY[vc] && (outst[vc] < MAX_OUT);
        if (xf) rx_q.push_back({vc, bus.ODATA});
        for (int v = 0; v < 2; v++) begin
            int old_cnt;
            old_cnt  = outst[v];
            outst[v] = old_cnt + ((xf && (int'(vc) == v)) ? 1 : 0)
                               - ((bus.IACK[v] && old_cnt > 0) ? 1 : 0);
        end
        cyc();
        if (acc) void'(offer_q.pop_front());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CORE_VALID = 1'b0;
        bus.CORE_HEAD  = 1'b0;
        bus.CORE_TAIL  = 1'b0;
        bus.CORE_DATA  = 32'd0;
        bus.IRDY       = 2'b11;
        bus.IACK       = 2'b00;
        bus.ILCK       = 2'b00;

        // Reset state
        repeat (2) cyc();
        rst_ = 1'b1;
        check("rst_core_ready", 64'(bus.CORE_READY), 64'd1);
        check("rst_ovalid", 64'(bus.OVALID), 64'd0);
        check("rst_ovch", 64'(bus.OVCH), 64'd0);
        check("rst_odata", 64'(bus.ODATA), 64'd0);

        // Single-flit packet: two-cycle latency, one valid cycle
        push(1'b1, 1'b1, 32'h0000_00A5);
        check("single_idle_cycle", 64'(bus.OVALID), 64'd0);
        cyc();
        check("single_ovalid", 64'(bus.OVALID), 64'd1);
        check("single_odata", 64'(bus.ODATA), 64'h6_0000_00A5);
        check("single_ovch", 64'(bus.OVCH), 64'd0);
        cyc();
        check("single_one_cycle", 64'(bus.OVALID), 64'd0);
        bus.IACK = 2'b01;
        cyc();
        bus.IACK = 2'b00;

        // Back-to-back single-flit packets: exactly one idle cycle between them
        push(1'b1, 1'b1, 32'h0000_0B01);
        push(1'b1, 1'b1, 32'h0000_0B02);
        check("b2b_first", 64'(bus.ODATA), 64'h6_0000_0B01);
        cyc();
        check("b2b_gap", 64'(bus.OVALID), 64'd0);
        cyc();
        check("b2b_second", 64'(bus.ODATA), 64'h6_0000_0B02);
        cyc();
        check("b2b_done", 64'(bus.OVALID), 64'd0);
        bus.IACK = 2'b01;
        repeat (2) cyc();
        bus.IACK = 2'b00;
        check("b2b_cnt0", 64'(dut.out_cnt_r[0]), 64'd0);

        // VC0 locked: 3-flit packet goes out on VC1 in consecutive cycles
        bus.ILCK = 2'b01;
        bus.IRDY = 2'b00;
        push(1'b1, 1'b0, 32'h0000_0011);
        push(1'b0, 1'b0, 32'h0000_0012);
        push(1'b0, 1'b1, 32'h0000_0013);
        bus.ILCK = 2'b00;
        bus.IRDY = 2'b11;
        check("lock_f1", 64'(bus.ODATA), 64'h4_0000_0011);
        check("lock_f1_vc", 64'(bus.OVCH), 64'd1);
        cyc();
        check("lock_f2", 64'(bus.ODATA), 64'h0_0000_0012);
        check("lock_f2_vc", 64'(bus.OVCH), 64'd1);
        cyc();
        check("lock_f3", 64'(bus.ODATA), 64'h2_0000_0013);
        cyc();
        check("lock_tail_idle", 64'(bus.OVALID), 64'd0);
        check("lock_cnt1", 64'(dut.out_cnt_r[1]), 64'd3);
        bus.IACK = 2'b10;
        repeat (4) cyc();
        bus.IACK = 2'b00;
        check("ack_at_zero_cnt1", 64'(dut.out_cnt_r[1]), 64'd0);

        // Body flit while idle is dropped and flags the sticky error
        push(1'b0, 1'b0, 32'h0000_DEAD);
        repeat (2) cyc();
        check("drop_no_output", 64'(bus.OVALID), 64'd0);
        check("drop_err", 64'(dut.err_r), 64'd1);
        check("drop_ready", 64'(bus.CORE_READY), 64'd1);
        push(1'b1, 1'b1, 32'h0000_0077);
        cyc();
        check("drop_next_pkt", 64'(bus.ODATA), 64'h6_0000_0077);
        cyc();
        bus.IACK = 2'b01;
        cyc();
        bus.IACK = 2'b00;

        // Credit limit: 6-flit packet with no acks stalls after MAX_OUT transfers
        rx_q.delete();
        outst[0] = 0;
        outst[1] = 0;
        for (int i = 0; i < 6; i++) offer_q.push_back({(i == 0), (i == 5), 32'h200 + 32'(i)});
        repeat (16) run_cycle();
        check("credit_xfers", 64'(rx_q.size()), 64'd4);
        check("credit_stall_valid", 64'(bus.OVALID), 64'd1);
        check("credit_stall_data", 64'(bus.ODATA[31:0]), 64'h204);
        check("credit_cnt0", 64'(dut.out_cnt_r[0]), 64'd4);
        repeat (2) run_cycle();
        check("credit_stall_stable", 64'(bus.ODATA[31:0]), 64'h204);
        bus.IACK = 2'b01;
        run_cycle();
        bus.IACK = 2'b00;
        repeat (5) run_cycle();
        check("credit_one_more", 64'(rx_q.size()), 64'd5);
        check("credit_next_data", 64'(bus.ODATA[31:0]), 64'h205);
        check("credit_next_valid", 64'(bus.OVALID), 64'd1);
        bus.IACK = 2'b01;
        for (int i = 0; i < 30 && !(rx_q.size() == 6 && outst[0] == 0); i++) run_cycle();
        bus.IACK = 2'b00;
        check("credit_drained", 64'(rx_q.size()), 64'd6);
        check("credit_cnt0_zero", 64'(dut.out_cnt_r[0]), 64'd0);

        // Router stall on VC0 fills the FIFO; nothing lost or duplicated
        rx_q.delete();
        for (int i = 0; i < 8; i++) offer_q.push_back({(i == 0), (i == 7), 32'h300 + 32'(i)});
        bus.IACK = 2'b01;
        repeat (3) run_cycle();
        bus.IRDY = 2'b10;
        for (int i = 0; i < 10 && bus.CORE_READY; i++) run_cycle();
        check("stall_ready_low", 64'(bus.CORE_READY), 64'd0);
        held = bus.ODATA;
        repeat (2) run_cycle();
        check("stall_odata_stable", 64'(bus.ODATA), 64'(held));
        check("stall_ovalid_high", 64'(bus.OVALID), 64'd1);
        bus.IRDY = 2'b11;
        for (int i = 0; i < 40 && !(offer_q.size() == 0 && rx_q.size() >= 8); i++) run_cycle();
        for (int i = 0; i < 10 && outst[0] != 0; i++) run_cycle();
        bus.IACK = 2'b00;
        check("stall_count", 64'(rx_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            check("stall_flit", 64'(rx_q[i][34:0]),
                  64'({(i == 0), (i == 7), 1'b0, 32'h300 + 32'(i)}));
        check("stall_cnt0_zero", 64'(dut.out_cnt_r[0]), 64'd0);

        // Transfer and ack in the same cycle keep the count unchanged
        bus.IRDY = 2'b00;
        push(1'b1, 1'b0, 32'h0000_0400);
        push(1'b0, 1'b0, 32'h0000_0401);
        push(1'b0, 1'b0, 32'h0000_0402);
        push(1'b0, 1'b1, 32'h0000_0403);
        bus.IRDY = 2'b01;
        repeat (2) cyc();
        bus.IRDY = 2'b00;
        check("same_cycle_pre", 64'(dut.out_cnt_r[0]), 64'd2);
        check("same_cycle_pre_data", 64'(bus.ODATA), 64'h0_0000_0402);
        bus.IRDY = 2'b01;
        bus.IACK = 2'b01;
        cyc();
        bus.IRDY = 2'b00;
        bus.IACK = 2'b00;
        check("same_cycle_cnt0", 64'(dut.out_cnt_r[0]), 64'd2);
        check("same_cycle_data", 64'(bus.ODATA), 64'h2_0000_0403);

        // Reset mid-packet with three flits buffered
        push(1'b1, 1'b0, 32'h0000_0500);
        push(1'b0, 1'b1, 32'h0000_0501);
        check("pre_reset_valid", 64'(bus.OVALID), 64'd1);
        rst_     = 1'b0;
        bus.IACK = 2'b11;
        cyc();
        rst_     = 1'b1;
        bus.IACK = 2'b00;
        check("mid_rst_ovalid", 64'(bus.OVALID), 64'd0);
        check("mid_rst_ready", 64'(bus.CORE_READY), 64'd1);
        check("mid_rst_cnt0", 64'(dut.out_cnt_r[0]), 64'd0);
        check("mid_rst_cnt1", 64'(dut.out_cnt_r[1]), 64'd0);
        check("mid_rst_err", 64'(dut.err_r), 64'd0);
        bus.IRDY = 2'b11;
        repeat (3) cyc();
        check("mid_rst_no_output", 64'(bus.OVALID), 64'd0);
        push(1'b1, 1'b1, 32'h0000_05A5);
        check("mid_rst_idle_latency", 64'(bus.OVALID), 64'd0);
        cyc();
        check("mid_rst_new_pkt", 64'(bus.ODATA), 64'h6_0000_05A5);
        cyc();
        bus.IACK = 2'b01;
        cyc();
        bus.IACK = 2'b00;

        // Randomized traffic against the flit-list and credit model
        rx_q.delete();
        offer_q.delete();
        exp_q.delete();
        outst[0] = 0;
        outst[1] = 0;
        stray    = 1'b0;
        for (int p = 0; p < 30; p++) begin
            int len;
            if (p == 0 || $urandom_range(0, 5) == 0) begin
                offer_q.push_back({1'b0, 1'($urandom_range(0, 1)), 32'($urandom)});
                stray = 1'b1;
            end
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                logic [33:0] f;
                f = {(i == 0), (i == len - 1), 32'($urandom)};
                offer_q.push_back(f);
                exp_q.push_back(f);
            end
        end
        for (int c = 0; c < 4000 && rx_q.size() < exp_q.size(); c++) begin
            core_en     = ($urandom_range(0, 3) != 0);
            bus.IRDY    = 2'($urandom_range(0, 3));
            bus.ILCK[0] = ($urandom_range(0, 3) == 0);
            bus.ILCK[1] = ($urandom_range(0, 3) == 0);
            bus.IACK[0] = (outst[0] > 0) && ($urandom_range(0, 1) == 1);
            bus.IACK[1] = (outst[1] > 0) && ($urandom_range(0, 1) == 1);
            run_cycle();
        end
        core_en  = 1'b1;
        bus.IACK = 2'b00;
        bus.ILCK = 2'b00;
        check("rand_count", 64'(rx_q.size()), 64'(exp_q.size()));
        pkt_vc = 1'b0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check("rand_flit", 64'(rx_q[i][34:0]),
                  64'({exp_q[i][33:32], 1'b0, exp_q[i][31:0]}));
            if (rx_q[i][34]) pkt_vc = rx_q[i][35];
            else check("rand_vc_in_packet", 64'(rx_q[i][35]), 64'(pkt_vc));
        end
        check("rand_err_sticky", 64'(dut.err_r), 64'(stray));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
